// File: rtl/clock_monitor_pkg.sv
// ============================================================================
// Module : clock_monitor_pkg
// Brief  : Shared FSM encodings, error-counter width and saturating helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package clock_monitor_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_STALL   = 2'd2;

    localparam int              ERR_W   = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] e);
        return (e == ERR_MAX) ? e : e + ERR_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clock_monitor_edge_detect.sv
// ============================================================================
// Module : edge_detect
// Brief  : Rising-edge detector for a signal synchronous to clk_in.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module edge_detect (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic rise
);

    logic sig_d;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig_in;
        end
    end

    assign rise = sig_in & ~sig_d;

endmodule

`default_nettype wire

// File: rtl/clock_monitor.sv
// ============================================================================
// Module : clock_monitor
// Brief  : Measures period/high time of a divided clock, checks against
//          expected values, reports lock, mismatch count and stall.
//          Define CLK_MON_DUTY_EN to measure and check the high time.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4,
    parameter int TOL      = 0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    input  logic [CNT_W-1:0] exp_period,
    input  logic [CNT_W-1:0] exp_high,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             locked,
    output logic             stall,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int               MATCH_W  = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] STALL_AT = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] TOL_V    = CNT_W'(TOL);
    localparam logic [MATCH_W-1:0] LOCK_V = MATCH_W'(LOCK_CNT);

    logic               rise;
    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   period_meas;
    logic [CNT_W-1:0]   period_diff;
    logic               period_ok;
    logic               duty_ok;
    logic               match;
    logic [MATCH_W-1:0] match_cnt;
    logic [MATCH_W-1:0] match_next;

    edge_detect u_edge_detect (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (sig_in),
        .rise   (rise)
    );

    // Stall fires at STALL_AT, so cnt saturating here only matters in IDLE/STALL.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign period_meas = cnt + CNT_W'(1);
    assign period_diff = (period_meas >= exp_period) ? (period_meas - exp_period)
                                                     : (exp_period - period_meas);
    assign period_ok   = (period_diff <= TOL_V);

`ifdef CLK_MON_DUTY_EN
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] high_diff;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
        end else if (rise) begin
            hcnt <= CNT_W'(1);
        end else if (sig_in && (hcnt != CNT_MAX)) begin
            hcnt <= hcnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            high_out <= '0;
        end else if ((state == ST_MEASURE) && rise) begin
            high_out <= hcnt;
        end
    end

    assign high_diff = (hcnt >= exp_high) ? (hcnt - exp_high) : (exp_high - hcnt);
    assign duty_ok   = (high_diff <= TOL_V);
`else
    logic unused_exp_high;

    assign unused_exp_high = ^exp_high;
    assign high_out        = '0;
    assign duty_ok         = 1'b1;
`endif

    assign match      = period_ok & duty_ok;
    assign match_next = (match_cnt == LOCK_V) ? match_cnt : match_cnt + MATCH_W'(1);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            period_out <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            stall      <= 1'b0;
            err_cnt    <= '0;
            match_cnt  <= '0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        period_out <= period_meas;
                        meas_valid <= 1'b1;
                        if (match) begin
                            match_cnt <= match_next;
                            if (match_next == LOCK_V) begin
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                            locked    <= 1'b0;
                            err_cnt   <= err_inc(err_cnt);
                        end
                    end else if (cnt == STALL_AT) begin
                        state     <= ST_STALL;
                        stall     <= 1'b1;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        err_cnt   <= err_inc(err_cnt);
                    end
                end
                ST_STALL: begin
                    // The edge ending a stall only restarts timing; its period is meaningless.
                    if (rise) begin
                        state <= ST_MEASURE;
                        stall <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_clock_monitor.sv
// ============================================================================
// Module : tb_clock_monitor
// Brief  : Scoreboard bench for clock_monitor (TOL=0 and TOL=1 instances).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_clock_monitor;

    localparam int NDUT     = 2;
    localparam int LOCK_CNT = 4;

    typedef struct {
        bit have_ref;
        bit stalled;
        bit prev;
        int last_rise;
        int high_cnt;
        int consec;
        int errs;
        bit locked;
        int last_p;
        int last_h;
    } model_t;

    typedef struct {
        int p;
        int h;
        bit locked;
        int errs;
    } meas_t;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       sig_in = 1'b0;
    logic [7:0] exp_period = 8'd0;
    logic [7:0] exp_high   = 8'd0;

    logic [7:0] period_o [NDUT];
    logic [7:0] high_o   [NDUT];
    logic [7:0] err_o    [NDUT];
    logic       valid_o  [NDUT];
    logic       locked_o [NDUT];
    logic       stall_o  [NDUT];

    model_t m [NDUT];
    meas_t  q [NDUT][$];
    int     cyc;
    int     checks = 0;
    int     errors = 0;

    always #5 clk_in = ~clk_in;

    clock_monitor #(.CNT_W(8), .LOCK_CNT(LOCK_CNT), .TOL(0)) dut0 (
        .clk_in     (clk_in),
        .rst        (rst),
        .sig_in     (sig_in),
        .exp_period (exp_period),
        .exp_high   (exp_high),
        .period_out (period_o[0]),
        .high_out   (high_o[0]),
        .meas_valid (valid_o[0]),
        .locked     (locked_o[0]),
        .stall      (stall_o[0]),
        .err_cnt    (err_o[0])
    );

    clock_monitor #(.CNT_W(8), .LOCK_CNT(LOCK_CNT), .TOL(1)) dut1 (
        .clk_in     (clk_in),
        .rst        (rst),
        .sig_in     (sig_in),
        .exp_period (exp_period),
        .exp_high   (exp_high),
        .period_out (period_o[1]),
        .high_out   (high_o[1]),
        .meas_valid (valid_o[1]),
        .locked     (locked_o[1]),
        .stall      (stall_o[1]),
        .err_cnt    (err_o[1])
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, idx, act, expv, $time);
        end
    endtask

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int high_view(input int h);
`ifdef CLK_MON_DUTY_EN
        return h;
`else
        return 0 * h;
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NDUT; i++) begin
            m[i] = '{default: 0};
            q[i].delete();
        end
        cyc = 0;
    endfunction

    // Reference: measure each rise-to-rise interval by cycle timestamps.
    function automatic void model_step(input int i, input bit s, input int ep, input int eh);
        bit rise;
        bit ok;
        int p;
        int h;
        rise      = s && !m[i].prev;
        m[i].prev = s;
        if (rise) begin
            if (m[i].have_ref && !m[i].stalled) begin
                p  = cyc - m[i].last_rise;
                h  = m[i].high_cnt;
                ok = absdiff(p, ep) <= i;
`ifdef CLK_MON_DUTY_EN
                ok = ok && (absdiff(h, eh) <= i);
`endif
                if (ok) begin
                    if (m[i].consec < LOCK_CNT) m[i].consec++;
                    if (m[i].consec == LOCK_CNT) m[i].locked = 1'b1;
                end else begin
                    m[i].consec = 0;
                    m[i].locked = 1'b0;
                    if (m[i].errs < 255) m[i].errs++;
                end
                m[i].last_p = p;
                m[i].last_h = h;
                q[i].push_back('{p: p, h: h, locked: m[i].locked, errs: m[i].errs});
            end
            m[i].have_ref  = 1'b1;
            m[i].stalled   = 1'b0;
            m[i].last_rise = cyc;
            m[i].high_cnt  = 1;
        end else begin
            if (s && m[i].high_cnt < 255) m[i].high_cnt++;
            if (m[i].have_ref && !m[i].stalled && (cyc - m[i].last_rise == 255)) begin
                m[i].stalled = 1'b1;
                m[i].locked  = 1'b0;
                m[i].consec  = 0;
                if (m[i].errs < 255) m[i].errs++;
            end
        end
    endfunction

    always @(posedge clk_in) begin
        if (!rst) begin
            cyc++;
            for (int i = 0; i < NDUT; i++) begin
                model_step(i, sig_in, int'(exp_period), int'(exp_high));
            end
        end
    end

    always @(negedge clk_in) begin
        for (int i = 0; i < NDUT; i++) begin
            meas_t e;
            bit    expv;
            expv = (q[i].size() > 0);
            chk("meas_valid", i, 32'(valid_o[i]), 32'(expv));
            if (expv) begin
                e = q[i].pop_front();
                if (valid_o[i]) begin
                    chk("sb_period", i, 32'(period_o[i]), 32'(e.p));
                    chk("sb_high",   i, 32'(high_o[i]),   32'(high_view(e.h)));
                    chk("sb_locked", i, 32'(locked_o[i]), 32'(e.locked));
                    chk("sb_err",    i, 32'(err_o[i]),    32'(e.errs));
                end
            end
            chk("locked", i, 32'(locked_o[i]), 32'(m[i].locked));
            chk("stall",  i, 32'(stall_o[i]),  32'(m[i].stalled));
            chk("err",    i, 32'(err_o[i]),    32'(m[i].errs));
            chk("period", i, 32'(period_o[i]), 32'(m[i].last_p));
            chk("high",   i, 32'(high_o[i]),   32'(high_view(m[i].last_h)));
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic run_div(input int h, input int l, input int n);
        repeat (n) begin
            sig_in = 1'b1;
            repeat (h) tick();
            sig_in = 1'b0;
            repeat (l) tick();
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        sig_in = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int h;
        int l;
        model_reset();
        tick();
        tick();
        chk("reset_period", 0, 32'(period_o[0]), 0);
        chk("reset_locked", 0, 32'(locked_o[0]), 0);
        chk("reset_err",    0, 32'(err_o[0]),    0);
        chk("reset_valid",  0, 32'(valid_o[0]),  0);

        // clk_in/2 square wave
        exp_period = 8'd2;
        exp_high   = 8'd1;
        rst = 1'b0;
        run_div(1, 1, 10);
        chk("div2_period", 0, 32'(period_o[0]), 2);
        chk("div2_high",   0, 32'(high_o[0]),   32'(high_view(1)));
        chk("div2_locked", 0, 32'(locked_o[0]), 1);
        chk("div2_err",    0, 32'(err_o[0]),    0);

        // /28, then an expected-period mismatch and relock
        do_reset();
        exp_period = 8'd28;
        exp_high   = 8'd14;
        run_div(14, 14, 6);
        chk("div28_period", 0, 32'(period_o[0]), 28);
        chk("div28_high",   0, 32'(high_o[0]),   32'(high_view(14)));
        chk("div28_locked", 0, 32'(locked_o[0]), 1);
        exp_period = 8'd27;
        run_div(14, 14, 1);
        exp_period = 8'd28;
        chk("mismatch_locked", 0, 32'(locked_o[0]), 0);
        chk("mismatch_err",    0, 32'(err_o[0]),    1);
        run_div(14, 14, 5);
        chk("relock_locked", 0, 32'(locked_o[0]), 1);
        chk("relock_err",    0, 32'(err_o[0]),    1);

        // stall and resume
        sig_in = 1'b0;
        repeat (260) tick();
        chk("stall_flag",   0, 32'(stall_o[0]),  1);
        chk("stall_locked", 0, 32'(locked_o[0]), 0);
        chk("stall_err",    0, 32'(err_o[0]),    2);
        run_div(14, 14, 3);
        chk("resume_stall",  0, 32'(stall_o[0]),  0);
        chk("resume_period", 0, 32'(period_o[0]), 28);
        chk("resume_err",    0, 32'(err_o[0]),    2);
        chk("resume_locked", 0, 32'(locked_o[0]), 0);

        // asynchronous reset mid-period while locked
        run_div(14, 14, 3);
        chk("prereset_locked", 0, 32'(locked_o[0]), 1);
        sig_in = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_period", 0, 32'(period_o[0]), 0);
        chk("midrst_high",   0, 32'(high_o[0]),   0);
        chk("midrst_locked", 0, 32'(locked_o[0]), 0);
        chk("midrst_err",    0, 32'(err_o[0]),    0);
        chk("midrst_stall",  0, 32'(stall_o[0]),  0);
        chk("midrst_valid",  0, 32'(valid_o[0]),  0);
        tick();
        sig_in = 1'b0;
        tick();
        rst = 1'b0;
        run_div(14, 14, 3);
        chk("postrst_period", 0, 32'(period_o[0]), 28);

        // tolerance: periods alternate 4/5 against exp_period=4
        do_reset();
        exp_period = 8'd4;
        exp_high   = 8'd2;
        for (int k = 0; k < 10; k++) begin
            run_div(2, (k % 2 == 1) ? 3 : 2, 1);
        end
        chk("tol_locked", 1, 32'(locked_o[1]), 1);
        chk("tol_err",    1, 32'(err_o[1]),    0);
        chk("tol_high",   1, 32'(high_o[1]),   32'(high_view(2)));

        // randomized dividers and expectations
        for (int it = 0; it < 40; it++) begin
            h = int'($urandom_range(1, 12));
            l = int'($urandom_range(1, 12));
            exp_period = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(2, 26)) : 8'(h + l);
            exp_high   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 12)) : 8'(h);
            run_div(h, l, int'($urandom_range(1, 4)));
            if ($urandom_range(0, 11) == 0) begin
                sig_in = 1'b0;
                repeat (258) tick();
            end
        end

        repeat (3) tick();
        for (int i = 0; i < NDUT; i++) begin
            chk("queue_drained", i, 32'(q[i].size()), 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
